maxnet_engine: RTL and testbench

Parametrised Maxnet winner-take-all engine: captures N unsigned activations, runs lateral-inhibition iterations (one per clock) until at most one activation is non-zero, stalls, or an iteration cap is hit, then reports the winner's original value and index. Generalises the fixed 32-bit Maxnet top to configurable channel count, width, inhibition strength and iteration limit. Adds start edge detection, tie and timeout flags, and an iteration counter.

---
 rtl/maxnet_pkg.sv | 25 ++
 rtl/maxnet_argmax.sv | 41 ++++
 rtl/maxnet_engine.sv | 237 +++++++++++++++++++++++
 tb/tb_maxnet_engine.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/maxnet_pkg.sv
// Shared types and width helpers for the Maxnet winner-take-all engine.
package maxnet_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ITER = 2'd1,
        ST_DONE = 2'd2
    } maxnet_state_e;

    // Channel index width; a single channel still needs one bit.
    function automatic int idx_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    // Activation sum width: wide enough that N full-scale values never wrap.
    function automatic int sum_width(input int n, input int w);
        return w + idx_width(n);
    endfunction

    // Iteration counter width: holds 0..max_iter inclusive.
    function automatic int cnt_width(input int max_iter);
        return (max_iter < 1) ? 1 : $clog2(max_iter + 1);
    endfunction

endpackage

// File: rtl/maxnet_argmax.sv
// Combinational argmax over N packed unsigned values.
// Lowest index wins among equal maxima; o_dup flags a repeated maximum.
module maxnet_argmax
    import maxnet_pkg::*;
#(
    parameter int N = 4,
    parameter int W = 32
) (
    input  logic [N*W-1:0]         i_vals,
    output logic [$clog2(N)-1:0]   o_idx,
    output logic [W-1:0]           o_max,
    output logic                   o_dup
);

    localparam int IW = idx_width(N);

    logic w_seen;

    // Strict greater-than keeps the earliest index on ties; second pass counts copies of the max.
    always_comb begin
        o_idx  = '0;
        o_max  = i_vals[W-1:0];
        o_dup  = 1'b0;
        w_seen = 1'b0;
        for (int i = 1; i < N; i++) begin
            if (i_vals[i*W +: W] > o_max) begin
                o_max = i_vals[i*W +: W];
                o_idx = IW'(i);
            end
        end
        for (int i = 0; i < N; i++) begin
            if (i_vals[i*W +: W] == o_max) begin
                if (w_seen) begin
                    o_dup = 1'b1;
                end
                w_seen = 1'b1;
            end
        end
    end

endmodule

// File: rtl/maxnet_engine.sv
// Maxnet winner-take-all engine: captures N activations on a start edge,
// applies one lateral-inhibition step per clock until a single survivor,
// a stall or the iteration cap, then reports the winner's original value.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   IDLE    | after reset, waiting for a start edge
//   ITER    | one inhibition step per clock, start edges ignored
//   DONE    | results held, a start edge recaptures and reruns
module maxnet_engine
    import maxnet_pkg::*;
#(
    parameter int N         = 4,
    parameter int W         = 32,
    parameter int EPS_SHIFT = 3,
    parameter int MAX_ITER  = 255
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic                          i_start,
    input  logic [N*W-1:0]                i_data_in,
    output logic                          o_busy,
    output logic                          o_done,
    output logic [W-1:0]                  o_max_value,
    output logic [$clog2(N)-1:0]          o_max_index,
    output logic                          o_tie,
    output logic                          o_timeout,
    output logic [$clog2(MAX_ITER+1)-1:0] o_iterations
);

    localparam int IW = idx_width(N);
    localparam int SW = sum_width(N, W);
    localparam int CW = cnt_width(MAX_ITER);

    maxnet_state_e r_state;
    maxnet_state_e w_state_nxt;

    logic           r_start_q;
    logic           w_edge;
    logic           w_capture;
    logic           w_finish;

    logic [W-1:0]   r_act  [N];
    logic [W-1:0]   r_orig [N];
    logic [W-1:0]   w_nxt  [N];
    logic [SW-1:0]  w_sum;
    logic [SW-1:0]  w_inh  [N];

    logic [CW-1:0]  r_cnt;
    logic [CW-1:0]  w_cnt_inc;

    logic [IW:0]    w_nz_cnt;
    logic [IW-1:0]  w_nz_idx;
    logic           w_same;
    logic           w_one;
    logic           w_none;
    logic           w_stall;
    logic           w_last;
    logic           w_term;
    logic           w_sel_nxt;

    logic [N*W-1:0] w_am_in;
    logic [IW-1:0]  w_am_idx;
    logic [W-1:0]   w_am_max;
    logic           w_am_dup;

    logic [IW-1:0]  w_win_idx;
    logic           w_win_tie;
    logic           w_win_to;

    logic           r_busy;
    logic           r_done;
    logic [W-1:0]   r_max_value;
    logic [IW-1:0]  r_max_index;
    logic           r_tie;
    logic           r_timeout;
    logic [CW-1:0]  r_iterations;

    assign w_edge    = i_start & ~r_start_q;
    assign w_cnt_inc = r_cnt + CW'(1);

    // One inhibition step: each channel loses 2^-EPS_SHIFT of everyone else's total, floored at zero.
    always_comb begin
        w_sum = '0;
        for (int i = 0; i < N; i++) begin
            w_sum = w_sum + SW'(r_act[i]);
        end
        for (int i = 0; i < N; i++) begin
            w_inh[i] = (w_sum - SW'(r_act[i])) >> EPS_SHIFT;
            w_nxt[i] = (SW'(r_act[i]) > w_inh[i]) ? (r_act[i] - w_inh[i][W-1:0]) : '0;
        end
    end

    // Survivor count, the lone survivor's index, and whether the step changed anything.
    always_comb begin
        w_nz_cnt = '0;
        w_nz_idx = '0;
        w_same   = 1'b1;
        for (int i = 0; i < N; i++) begin
            if (w_nxt[i] != '0) begin
                w_nz_cnt = w_nz_cnt + (IW+1)'(1);
                w_nz_idx = IW'(i);
            end
            if (w_nxt[i] != r_act[i]) begin
                w_same = 1'b0;
            end
        end
    end

    assign w_one     = (w_nz_cnt == (IW+1)'(1));
    assign w_none    = (w_nz_cnt == '0);
    assign w_stall   = w_same && (w_nz_cnt >= (IW+1)'(2));
    assign w_last    = (w_cnt_inc >= CW'(MAX_ITER));
    assign w_term    = w_one | w_none | w_stall | w_last;

    // Only a cap-limited run ranks the new activations; every other exit ranks the current ones.
    assign w_sel_nxt = !(w_one || w_none || w_stall);

    // Pack whichever activation set the single argmax instance should rank.
    always_comb begin
        w_am_in = '0;
        for (int i = 0; i < N; i++) begin
            w_am_in[i*W +: W] = w_sel_nxt ? w_nxt[i] : r_act[i];
        end
    end

    maxnet_argmax #(
        .N (N),
        .W (W)
    ) u_argmax (
        .i_vals (w_am_in),
        .o_idx  (w_am_idx),
        .o_max  (w_am_max),
        .o_dup  (w_am_dup)
    );

    // Winner and flags by exit reason, in priority order.
    always_comb begin
        w_win_idx = w_am_idx;
        w_win_tie = w_am_dup;
        w_win_to  = 1'b0;
        if (w_one) begin
            w_win_idx = w_nz_idx;
            w_win_tie = 1'b0;
        end else if (w_none) begin
            w_win_tie = w_am_dup && (w_am_max != '0);
        end else if (!w_stall) begin
            w_win_to  = 1'b1;
        end
    end

    // Next-state and capture/finish strobes.
    always_comb begin
        w_state_nxt = r_state;
        w_capture   = 1'b0;
        w_finish    = 1'b0;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (w_edge) begin
                    w_capture   = 1'b1;
                    w_state_nxt = ST_ITER;
                end
            end
            ST_ITER: begin
                if (w_term) begin
                    w_finish    = 1'b1;
                    w_state_nxt = ST_DONE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State register and start history.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state   <= ST_IDLE;
            r_start_q <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_start_q <= i_start;
        end
    end

    // Activation datapath, iteration counter and registered results.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < N; i++) begin
                r_act[i]  <= '0;
                r_orig[i] <= '0;
            end
            r_cnt        <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_max_value  <= '0;
            r_max_index  <= '0;
            r_tie        <= 1'b0;
            r_timeout    <= 1'b0;
            r_iterations <= '0;
        end else if (w_capture) begin
            for (int i = 0; i < N; i++) begin
                r_act[i]  <= i_data_in[i*W +: W];
                r_orig[i] <= i_data_in[i*W +: W];
            end
            r_cnt     <= '0;
            r_busy    <= 1'b1;
            r_done    <= 1'b0;
            r_tie     <= 1'b0;
            r_timeout <= 1'b0;
        end else if (r_state == ST_ITER) begin
            for (int i = 0; i < N; i++) begin
                r_act[i] <= w_nxt[i];
            end
            r_cnt <= w_cnt_inc;
            if (w_finish) begin
                r_max_value  <= r_orig[w_win_idx];
                r_max_index  <= w_win_idx;
                r_tie        <= w_win_tie;
                r_timeout    <= w_win_to;
                r_iterations <= w_cnt_inc;
                r_done       <= 1'b1;
                r_busy       <= 1'b0;
            end
        end
    end

    assign o_busy       = r_busy;
    assign o_done       = r_done;
    assign o_max_value  = r_max_value;
    assign o_max_index  = r_max_index;
    assign o_tie        = r_tie;
    assign o_timeout    = r_timeout;
    assign o_iterations = r_iterations;

endmodule

// File: tb/tb_maxnet_engine.sv
// Directed bench for maxnet_engine: default instance plus a MAX_ITER=4 instance.
module tb_maxnet_engine;

    localparam int N = 4;
    localparam int W = 32;

    logic           clk = 1'b0;
    logic           rst;
    logic           start;
    logic           start_t;
    logic [N*W-1:0] data_in;

    logic           busy, done, tie, timeout;
    logic [W-1:0]   max_value;
    logic [1:0]     max_index;
    logic [7:0]     iterations;

    logic           t_busy, t_done, t_tie, t_timeout;
    logic [W-1:0]   t_max_value;
    logic [1:0]     t_max_index;
    logic [2:0]     t_iterations;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    maxnet_engine #(.N(N), .W(W), .EPS_SHIFT(3), .MAX_ITER(255)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_start      (start),
        .i_data_in    (data_in),
        .o_busy       (busy),
        .o_done       (done),
        .o_max_value  (max_value),
        .o_max_index  (max_index),
        .o_tie        (tie),
        .o_timeout    (timeout),
        .o_iterations (iterations)
    );

    maxnet_engine #(.N(N), .W(W), .EPS_SHIFT(3), .MAX_ITER(4)) dut_t (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_start      (start_t),
        .i_data_in    (data_in),
        .o_busy       (t_busy),
        .o_done       (t_done),
        .o_max_value  (t_max_value),
        .o_max_index  (t_max_index),
        .o_tie        (t_tie),
        .o_timeout    (t_timeout),
        .o_iterations (t_iterations)
    );

    // Raise start at a negedge with new data; returns just after the capture edge E0.
    task automatic launch(input logic [W-1:0] d0, input logic [W-1:0] d1,
                          input logic [W-1:0] d2, input logic [W-1:0] d3, input bit sel);
        @(negedge clk);
        data_in = {d3, d2, d1, d0};
        if (sel) start_t = 1'b1;
        else     start   = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // Edges after E0 until done rises; -1 if the budget runs out.
    task automatic wait_done(input bit sel, output int k);
        k = -1;
        for (int i = 1; i <= 300; i++) begin
            @(posedge clk);
            #1;
            if ((sel ? t_done : done) === 1'b1) begin
                k = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; start_t = 1'b0; data_in = '0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if ({busy, done, tie, timeout} !== 4'b0000) begin n_err++; $display("FAIL reset_flags: got %b want 0000", {busy, done, tie, timeout}); end
        n_cmp++; if ({max_value, max_index, iterations} !== 42'd0) begin n_err++; $display("FAIL reset_results: got %0d/%0d/%0d want 0/0/0", max_value, max_index, iterations); end
        n_cmp++; if ({t_busy, t_done, t_tie, t_timeout, t_max_value, t_max_index, t_iterations} !== 41'd0) begin n_err++; $display("FAIL reset_cap_inst: got nonzero outputs"); end
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++; if ({busy, done} !== 2'b00) begin n_err++; $display("FAIL idle_quiet: got busy/done %b want 00", {busy, done}); end
    endtask

    task automatic test_basic();
        int k;
        launch(32'd10, 32'd40, 32'd25, 32'd5, 1'b0);
        n_cmp++; if ({busy, done} !== 2'b10) begin n_err++; $display("FAIL basic_e0: got busy/done %b want 10", {busy, done}); end
        start = 1'b0;
        wait_done(1'b0, k);
        n_cmp++; if (k !== 7) begin n_err++; $display("FAIL basic_latency: got %0d want 7", k); end
        n_cmp++; if (max_index !== 2'd1) begin n_err++; $display("FAIL basic_index: got %0d want 1", max_index); end
        n_cmp++; if (max_value !== 32'd40) begin n_err++; $display("FAIL basic_value: got %0d want 40", max_value); end
        n_cmp++; if (iterations !== 8'd7) begin n_err++; $display("FAIL basic_iter: got %0d want 7", iterations); end
        n_cmp++; if ({busy, tie, timeout} !== 3'b000) begin n_err++; $display("FAIL basic_flags: got busy/tie/timeout %b want 000", {busy, tie, timeout}); end
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if ({done, max_value, max_index} !== {1'b1, 32'd40, 2'd1}) begin n_err++; $display("FAIL basic_hold: got done %b value %0d index %0d want 1/40/1", done, max_value, max_index); end
    endtask

    task automatic test_stall();
        int k;
        launch(32'd20, 32'd20, 32'd0, 32'd0, 1'b0);
        n_cmp++; if ({busy, done} !== 2'b10) begin n_err++; $display("FAIL stall_done_drop: got busy/done %b want 10", {busy, done}); end
        start = 1'b0;
        wait_done(1'b0, k);
        n_cmp++; if (k !== 11) begin n_err++; $display("FAIL stall_latency: got %0d want 11", k); end
        n_cmp++; if ({max_index, max_value} !== {2'd0, 32'd20}) begin n_err++; $display("FAIL stall_winner: got %0d/%0d want 0/20", max_index, max_value); end
        n_cmp++; if ({tie, timeout} !== 2'b10) begin n_err++; $display("FAIL stall_flags: got tie/timeout %b want 10", {tie, timeout}); end
        n_cmp++; if (iterations !== 8'd11) begin n_err++; $display("FAIL stall_iter: got %0d want 11", iterations); end
    endtask

    task automatic test_single_and_zero();
        int k;
        launch(32'd0, 32'd0, 32'd99, 32'd0, 1'b0);
        start = 1'b0;
        wait_done(1'b0, k);
        n_cmp++; if (k !== 1) begin n_err++; $display("FAIL single_latency: got %0d want 1", k); end
        n_cmp++; if ({max_index, max_value, tie} !== {2'd2, 32'd99, 1'b0}) begin n_err++; $display("FAIL single_result: got %0d/%0d tie %b want 2/99/0", max_index, max_value, tie); end
        n_cmp++; if (iterations !== 8'd1) begin n_err++; $display("FAIL single_iter: got %0d want 1", iterations); end
        launch(32'd0, 32'd0, 32'd0, 32'd0, 1'b0);
        start = 1'b0;
        wait_done(1'b0, k);
        n_cmp++; if (k !== 1) begin n_err++; $display("FAIL zero_latency: got %0d want 1", k); end
        n_cmp++; if ({max_index, max_value, tie, timeout} !== {2'd0, 32'd0, 1'b0, 1'b0}) begin n_err++; $display("FAIL zero_result: got %0d/%0d tie %b to %b want 0/0/0/0", max_index, max_value, tie, timeout); end
    endtask

    task automatic test_timeout();
        int k;
        launch(32'd10, 32'd40, 32'd25, 32'd5, 1'b1);
        n_cmp++; if (t_busy !== 1'b1) begin n_err++; $display("FAIL cap_busy: got %b want 1", t_busy); end
        start_t = 1'b0;
        wait_done(1'b1, k);
        n_cmp++; if (k !== 4) begin n_err++; $display("FAIL cap_latency: got %0d want 4", k); end
        n_cmp++; if ({t_timeout, t_tie} !== 2'b10) begin n_err++; $display("FAIL cap_flags: got timeout/tie %b want 10", {t_timeout, t_tie}); end
        n_cmp++; if ({t_max_index, t_max_value} !== {2'd1, 32'd40}) begin n_err++; $display("FAIL cap_winner: got %0d/%0d want 1/40", t_max_index, t_max_value); end
        n_cmp++; if (t_iterations !== 3'd4) begin n_err++; $display("FAIL cap_iter: got %0d want 4", t_iterations); end
    endtask

    task automatic test_held_start();
        int k;
        int captures;
        int first_done;
        logic prev_busy;
        launch(32'd10, 32'd40, 32'd25, 32'd5, 1'b0);
        captures = 1; first_done = -1; prev_busy = busy;
        for (int i = 1; i <= 10; i++) begin
            @(posedge clk);
            #1;
            if (busy && !prev_busy) captures++;
            if (done && first_done < 0) first_done = i;
            prev_busy = busy;
        end
        n_cmp++; if (captures !== 1) begin n_err++; $display("FAIL held_captures: got %0d want 1", captures); end
        n_cmp++; if (first_done !== 7) begin n_err++; $display("FAIL held_latency: got %0d want 7", first_done); end
        n_cmp++; if ({done, busy, iterations} !== {1'b1, 1'b0, 8'd7}) begin n_err++; $display("FAIL held_state: got done %b busy %b iter %0d want 1/0/7", done, busy, iterations); end
        @(negedge clk);
        start = 1'b0;
        launch(32'd0, 32'd0, 32'd99, 32'd0, 1'b0);
        n_cmp++; if ({done, busy} !== 2'b01) begin n_err++; $display("FAIL rerun_e0: got done/busy %b want 01", {done, busy}); end
        start = 1'b0;
        wait_done(1'b0, k);
        n_cmp++; if ({k[7:0], max_index, max_value} !== {8'd1, 2'd2, 32'd99}) begin n_err++; $display("FAIL rerun_result: got k %0d idx %0d val %0d want 1/2/99", k, max_index, max_value); end
    endtask

    task automatic test_mid_reset();
        int k;
        launch(32'd10, 32'd40, 32'd25, 32'd5, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        n_cmp++; if ({busy, done} !== 2'b10) begin n_err++; $display("FAIL midrst_running: got busy/done %b want 10", {busy, done}); end
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        n_cmp++; if ({busy, done, tie, timeout, max_value, max_index, iterations} !== 46'd0) begin n_err++; $display("FAIL midrst_clear: got busy %b done %b val %0d idx %0d iter %0d want all 0", busy, done, max_value, max_index, iterations); end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL midrst_restart: got busy %b want 1", busy); end
        start = 1'b0;
        wait_done(1'b0, k);
        n_cmp++; if (k !== 7) begin n_err++; $display("FAIL midrst_latency: got %0d want 7", k); end
        n_cmp++; if ({max_index, max_value, iterations} !== {2'd1, 32'd40, 8'd7}) begin n_err++; $display("FAIL midrst_result: got %0d/%0d/%0d want 1/40/7", max_index, max_value, iterations); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_single_and_zero();
        test_timeout();
        test_held_start();
        test_mid_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
